// File: rtl/ipa_burst_scheduler.sv
// ipa_burst_scheduler
// Round-robin, burst-granular scheduler that shares the downstream pixel FIFO
// write port between two slave pixel sources. A slave is granted for
// BURST_LEN accepted beats. Each accepted beat is registered onto the slvx_*
// bus one cycle later. FIFO backpressure stalls the burst, and master-complete
// aborts the burst and holds off all grants.
//
// Optional feature, controlled by the macro ARB_TIMEOUT_EN:
//   When the macro is defined, a granted slave that stays idle for TIMEOUT
//   consecutive cycles loses its grant, and o_timeout_abort pulses.
//   When the macro is undefined, a grant is held until BURST_LEN beats transfer.

module ipa_burst_scheduler #(
  parameter int DW        = 32,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_slv0_data_valid,
  input  logic [1:0]    i_slv0_mode,
  input  logic [7:0]    i_slv0_proc_val,
  input  logic [DW-1:0] i_slv0_data,
  output logic          o_slv0_ready,
  input  logic          i_slv1_data_valid,
  input  logic [1:0]    i_slv1_mode,
  input  logic [7:0]    i_slv1_proc_val,
  input  logic [DW-1:0] i_slv1_data,
  output logic          o_slv1_ready,
  input  logic          i_fifo_full,
  input  logic          i_mstr_cmplt,
  output logic          o_slvx_data_valid,
  output logic [1:0]    o_slvx_mode,
  output logic [7:0]    o_slvx_proc_val,
  output logic [DW-1:0] o_slvx_data,
  output logic          o_slvx_src,
  output logic [1:0]    o_grant,
`ifdef ARB_TIMEOUT_EN
  output logic          o_timeout_abort,
`endif
  output logic          o_burst_done
);

  // Both limits are held in 8-bit counters, so they must lie in 1..255.
  if (BURST_LEN < 1 || BURST_LEN > 255 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_badParams
    $error("ipa_burst_scheduler: BURST_LEN and TIMEOUT must be in 1..255");
  end

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [7:0]  r_beatCnt;
  logic        r_lastServed;

  logic        w_xfer0;
  logic        w_xfer1;
  logic        w_xfer;
  logic        w_xferSrc;
  logic        w_burstEnd;
  logic        w_ownerSrc;
  logic        w_abortBurst;

  // Round-robin pick. When both slaves request, the one that was not served last wins.
  function automatic state_t arbitrate(input logic v0, input logic v1, input logic lastSrv);
    state_t pick;
    pick = IDLE;
    if (v0 && v1) begin
      pick = lastSrv ? GNT0 : GNT1;
    end else if (v0) begin
      pick = GNT0;
    end else if (v1) begin
      pick = GNT1;
    end
    return pick;
  endfunction

  // The ready path is purely combinational, so a stall takes effect in the same cycle.
  always_comb begin
    o_slv0_ready = (r_state == GNT0) & ~i_fifo_full & ~i_mstr_cmplt;
    o_slv1_ready = (r_state == GNT1) & ~i_fifo_full & ~i_mstr_cmplt;
    o_grant      = {r_state == GNT1, r_state == GNT0};
    w_xfer0      = i_slv0_data_valid & o_slv0_ready;
    w_xfer1      = i_slv1_data_valid & o_slv1_ready;
    w_xfer       = w_xfer0 | w_xfer1;
    w_xferSrc    = w_xfer1;
    w_ownerSrc   = (r_state == GNT1);
    w_burstEnd   = w_xfer & (r_beatCnt == LAST_BEAT);
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_idleCnt;
  logic       w_idleCycle;
  logic       r_timeoutAbort;

  // A granted owner is idle when it has nothing to offer and the FIFO is not blocking it.
  always_comb begin
    w_idleCycle  = (((r_state == GNT0) & ~i_slv0_data_valid) |
                    ((r_state == GNT1) & ~i_slv1_data_valid)) & ~i_fifo_full;
    w_abortBurst = w_idleCycle & ~i_mstr_cmplt & (r_idleCnt == TIMEOUT_LAST);
  end

  // The idle run length restarts on any transfer, grant change or non-idle cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idleCnt      <= 8'd0;
      r_timeoutAbort <= 1'b0;
    end else begin
      r_timeoutAbort <= w_abortBurst;
      if (!w_idleCycle || w_xfer || (w_nextState != r_state)) begin
        r_idleCnt <= 8'd0;
      end else begin
        r_idleCnt <= r_idleCnt + 8'd1;
      end
    end
  end

  assign o_timeout_abort = r_timeoutAbort;
`else
  assign w_abortBurst = 1'b0;
`endif

  // Next-state selection. Master-complete overrides everything, and burst end re-arbitrates with no bubble.
  always_comb begin
    w_nextState = r_state;
    if (i_mstr_cmplt) begin
      w_nextState = IDLE;
    end else begin
      unique case (r_state)
        IDLE: w_nextState = arbitrate(i_slv0_data_valid, i_slv1_data_valid, r_lastServed);
        GNT0, GNT1: begin
          if (w_burstEnd || w_abortBurst) begin
            w_nextState = arbitrate(i_slv0_data_valid, i_slv1_data_valid, w_ownerSrc);
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Beat counter and round-robin history. An abort clears the count but leaves the history alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_beatCnt    <= 8'd0;
      r_lastServed <= 1'b1;
    end else if (i_mstr_cmplt) begin
      r_beatCnt <= 8'd0;
    end else if (w_burstEnd || w_abortBurst) begin
      r_beatCnt    <= 8'd0;
      r_lastServed <= w_ownerSrc;
    end else if (w_xfer) begin
      r_beatCnt <= r_beatCnt + 8'd1;
    end
  end

  // Output beat register. Payload fields hold between beats, and only the valid and done flags drop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_slvx_data_valid <= 1'b0;
      o_slvx_mode       <= 2'd0;
      o_slvx_proc_val   <= 8'd0;
      o_slvx_data       <= '0;
      o_slvx_src        <= 1'b0;
      o_burst_done      <= 1'b0;
    end else begin
      o_slvx_data_valid <= w_xfer;
      o_burst_done      <= w_burstEnd;
      if (w_xfer) begin
        o_slvx_src      <= w_xferSrc;
        o_slvx_mode     <= w_xferSrc ? i_slv1_mode     : i_slv0_mode;
        o_slvx_proc_val <= w_xferSrc ? i_slv1_proc_val : i_slv0_proc_val;
        o_slvx_data     <= w_xferSrc ? i_slv1_data     : i_slv0_data;
      end
    end
  end

endmodule

// File: tb/tb_ipa_burst_scheduler.sv
// tb_ipa_burst_scheduler
// Randomised phases drive the scheduler with BURST_LEN=4. A transaction-level
// model predicts which beats should be accepted, and queues them. A separate
// monitor pops the queue each time the DUT presents a registered beat.
// ARB_TIMEOUT_EN only adds a port connection here. The model covers the
// default behaviour.

module tb_ipa_burst_scheduler;

  localparam int DW    = 32;
  localparam int BURST = 4;

  logic          clk;
  logic          rst;
  logic          v0, v1;
  logic [1:0]    mode0, mode1;
  logic [7:0]    proc0, proc1;
  logic [DW-1:0] data0, data1;
  logic          rdy0, rdy1;
  logic          fifoFull;
  logic          mstrCmplt;
  logic          xValid;
  logic [1:0]    xMode;
  logic [7:0]    xProc;
  logic [DW-1:0] xData;
  logic          xSrc;
  logic [1:0]    grant;
  logic          burstDone;
`ifdef ARB_TIMEOUT_EN
  logic          timeoutAbort;
`endif

  ipa_burst_scheduler #(.DW(DW), .BURST_LEN(BURST), .TIMEOUT(8)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_slv0_data_valid(v0),
    .i_slv0_mode(mode0),
    .i_slv0_proc_val(proc0),
    .i_slv0_data(data0),
    .o_slv0_ready(rdy0),
    .i_slv1_data_valid(v1),
    .i_slv1_mode(mode1),
    .i_slv1_proc_val(proc1),
    .i_slv1_data(data1),
    .o_slv1_ready(rdy1),
    .i_fifo_full(fifoFull),
    .i_mstr_cmplt(mstrCmplt),
    .o_slvx_data_valid(xValid),
    .o_slvx_mode(xMode),
    .o_slvx_proc_val(xProc),
    .o_slvx_data(xData),
    .o_slvx_src(xSrc),
    .o_grant(grant),
`ifdef ARB_TIMEOUT_EN
    .o_timeout_abort(timeoutAbort),
`endif
    .o_burst_done(burstDone)
  );

  typedef struct {
    logic          src;
    logic [DW-1:0] data;
    logic [1:0]    mode;
    logic [7:0]    proc;
    logic          done;
  } beat_t;

  beat_t expQ[$];
  int    total = 0;
  int    bad   = 0;

  // Model state: owner is -1 for no owner, or 0/1 for the granted slave.
  int owner      = -1;
  int beatsTaken = 0;
  int lastSrv    = 1;
  int cnt0       = 0;
  int cnt1       = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value and records the result.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Round-robin choice from the request pattern and the most recently served slave.
  function automatic int pickOwner(input logic a, input logic b, input int last);
    if (a && b) return 1 - last;
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  // Checks one cycle of combinational outputs, queues any accepted beat, and advances the model.
  task automatic modelStep();
    logic expR0, expR1, take;
    beat_t b;
    expR0 = (owner == 0) && !fifoFull && !mstrCmplt;
    expR1 = (owner == 1) && !fifoFull && !mstrCmplt;
    checkOutput("grant", 64'(grant), (owner == 0) ? 64'd1 : (owner == 1) ? 64'd2 : 64'd0);
    checkOutput("slv0_ready", 64'(rdy0), 64'(expR0));
    checkOutput("slv1_ready", 64'(rdy1), 64'(expR1));
    take = (expR0 && v0) || (expR1 && v1);
    if (rst) begin
      owner = -1;
      beatsTaken = 0;
      lastSrv = 1;
    end else if (mstrCmplt) begin
      owner = -1;
      beatsTaken = 0;
    end else if (take) begin
      b.src  = (owner == 1);
      b.data = (owner == 1) ? data1 : data0;
      b.mode = (owner == 1) ? mode1 : mode0;
      b.proc = (owner == 1) ? proc1 : proc0;
      beatsTaken++;
      b.done = (beatsTaken == BURST);
      expQ.push_back(b);
      if (owner == 1) cnt1++; else cnt0++;
      if (beatsTaken == BURST) begin
        beatsTaken = 0;
        lastSrv = owner;
        owner = pickOwner(v0, v1, lastSrv);
      end
    end else if (owner == -1) begin
      owner = pickOwner(v0, v1, lastSrv);
    end
  endtask

  // Runs one phase of cycles. Each input is high with the given percent probability.
  task automatic applyStimulus(input int cycles, input int p0, input int p1,
                               input int pFull, input int pMstr, input int pRst);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      rst       = ($urandom_range(99) < pRst);
      v0        = ($urandom_range(99) < p0);
      v1        = ($urandom_range(99) < p1);
      fifoFull  = ($urandom_range(99) < pFull);
      mstrCmplt = ($urandom_range(99) < pMstr);
      mode0     = 2'($urandom);
      mode1     = 2'($urandom);
      proc0     = 8'($urandom);
      proc1     = 8'($urandom);
      data0     = 32'hA000_0000 + 32'(cnt0);
      data1     = 32'hB000_0000 + 32'(cnt1);
      #3;
      modelStep();
    end
  endtask

  // Monitor: each registered beat must match the oldest queued expectation.
  initial begin
    beat_t e;
    forever begin
      @(posedge clk);
      #2;
      if (xValid === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_beat", 64'(xValid), 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("slvx_src", 64'(xSrc), 64'(e.src));
          checkOutput("slvx_data", 64'(xData), 64'(e.data));
          checkOutput("slvx_mode", 64'(xMode), 64'(e.mode));
          checkOutput("slvx_proc_val", 64'(xProc), 64'(e.proc));
          checkOutput("burst_done", 64'(burstDone), 64'(e.done));
        end
      end else begin
        if (expQ.size() != 0) begin
          checkOutput("missing_beat", 64'(xValid), 64'd1);
          void'(expQ.pop_front());
        end
        if (burstDone !== 1'b0) checkOutput("burst_done_idle", 64'(burstDone), 64'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; fifoFull = 1'b0; mstrCmplt = 1'b0;
    mode0 = '0; mode1 = '0; proc0 = '0; proc1 = '0; data0 = '0; data1 = '0;
    $display("[TB] starting ipa_burst_scheduler bench");
    applyStimulus(3, 0, 0, 0, 0, 100);
    checkOutput("reset_valid", 64'(xValid), 64'd0);
    checkOutput("reset_data", 64'(xData), 64'd0);
    checkOutput("reset_mode", 64'(xMode), 64'd0);
    checkOutput("reset_proc", 64'(xProc), 64'd0);
    checkOutput("reset_src", 64'(xSrc), 64'd0);
    checkOutput("reset_done", 64'(burstDone), 64'd0);
    applyStimulus(12, 100, 0, 0, 0, 0);
    applyStimulus(3, 0, 0, 0, 0, 100);
    applyStimulus(26, 100, 100, 0, 0, 0);
    applyStimulus(60, 100, 100, 30, 0, 0);
    applyStimulus(60, 50, 100, 0, 0, 0);
    applyStimulus(80, 90, 90, 10, 8, 0);
    applyStimulus(2000, 70, 70, 20, 4, 1);
    applyStimulus(4, 0, 0, 0, 0, 0);
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ipa_burst_scheduler.md
Name: ipa_burst_scheduler

Overview:
Round-robin, burst-granular scheduler that shares the single downstream pixel FIFO between two slave requesters (slv0, slv1) of the image-processing accelerator.
It grants one slave at a time for BURST_LEN beats and registers the selected beat onto the slvx_* bus. It honours FIFO backpressure and the master-complete abort.
It sits between the slave-side pixel sources and the write port of the processing FIFO.

Parameters:
DW, 32, pixel data width of slvN_data / slvx_data
BURST_LEN, 16, beats per grant; legal range 1..255
TIMEOUT, 64, idle-cycle limit for a granted slave (used only with ARB_TIMEOUT_EN); legal range 1..255

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
slv0_data_valid  in  1  slave 0 beat valid
slv0_mode  in  2  slave 0 processing mode
slv0_proc_val  in  8  slave 0 processing value
slv0_data  in  DW  slave 0 pixel data
slv0_ready  out  1  slave 0 beat accepted this cycle when valid&ready
slv1_data_valid, slv1_mode, slv1_proc_val, slv1_data, slv1_ready  same directions/widths as slave 0, for slave 1
fifo_full  in  1  downstream FIFO full
mstr_cmplt  in  1  master complete; aborts and holds off all grants
slvx_data_valid  out  1  registered beat valid (FIFO write enable)
slvx_mode  out  2  registered mode of beat
slvx_proc_val  out  8  registered proc value of beat
slvx_data  out  DW  registered pixel data
slvx_src  out  1  source slave of registered beat
grant  out  2  one-hot current owner, 00 = none
burst_done  out  1  1-cycle pulse with the final beat of a burst

Behaviour:
- Reset: every output 0; FSM in IDLE; beat_cnt=0; last_served=1, so slv0 wins the first tie.
- FSM states: IDLE, GNT0, GNT1. grant = {state==GNT1, state==GNT0}.
- slvN_ready = (state==GNTN) & ~fifo_full & ~mstr_cmplt. This path is combinational.
- Transfer: a transfer occurs when slvN_data_valid & slvN_ready.
  - Next cycle: slvx_* <= slvN_*, slvx_data_valid<=1, slvx_src<=N. Latency is 1 cycle.
  - In any cycle without a transfer, slvx_data_valid<=0. The data/mode/proc_val/src outputs hold their last values.
- beat_cnt increments on each transfer.
  - On the transfer where beat_cnt==BURST_LEN-1, burst_done<=1 (aligned with that beat's slvx_data_valid), beat_cnt<=0, last_served<=N, and the grant is re-arbitrated in the same edge.
- Arbitration (from IDLE, or at burst end):
  - Target the slave whose valid is high.
  - If both are high, target the slave != last_served.
  - If neither is high, go to IDLE.
  - No bubble cycle between back-to-back bursts.
- Within a burst the grant is held even if the owner drops valid. The other slave waits; beat_cnt does not advance.
- fifo_full stalls: ready is low, no transfer, beat_cnt and state unchanged. Releasing fifo_full resumes on that cycle.
- mstr_cmplt=1:
  - Next state is IDLE, beat_cnt<=0, no transfer. last_served is unchanged. No burst_done.
  - The FSM stays in IDLE while mstr_cmplt is high.
  - The beat registered in the previous cycle still appears on slvx_* (no retraction).
- rst mid-burst: the same clear as the reset values; an in-flight registered beat is dropped (slvx_data_valid<=0).
- beat_cnt width is 8 bits; it never exceeds BURST_LEN-1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit idle_cnt counts consecutive cycles in GNTN with slvN_data_valid=0 and fifo_full=0. It clears on any transfer or state change.
  - When idle_cnt reaches TIMEOUT, the burst is aborted: last_served<=N, beat_cnt<=0, re-arbitrate, no burst_done.
  - Output timeout_abort (1 bit, reset 0) pulses for 1 cycle.
- Not defined: no idle_cnt and no timeout_abort port; a grant is held indefinitely until BURST_LEN beats transfer.

Test Plan:
- Single source: rst then slv0_valid=1 continuously, BURST_LEN=4, slv1 idle. Expect 4 beats with slvx_src=0 and burst_done on beat 4. Grant stays 01 with no bubble; beats continue.
- Contention: both valid from cycle 0, BURST_LEN=4. Expect grant sequence 01x4 beats, 10x4, 01x4. slvx_data matches the source counter patterns (0xA000_0000+i, 0xB000_0000+i).
- Backpressure: fifo_full=1 for 3 cycles mid-burst after beat 2 (slv1 valid too). Expect slv0_ready=0 for those cycles, no slvx_data_valid, and grant held. The burst completes 4 beats after release.
- Owner gap: slv0 drops valid for 5 cycles after beat 1 while slv1 valid. Expect grant stays 01 and slv1_ready=0; the burst completes, then grant moves to 10.
- Abort: mstr_cmplt=1 after beat 2. Expect grant=00 next cycle, no burst_done, and no grant while mstr_cmplt is high. On release, arbitration resumes with last_served unchanged.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=8): granted slv0 idle with slv1 valid. Expect timeout_abort at idle cycle 8, then grant=10.
